// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared FIR constants and the requantize helper function.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int FIR_DATA_W = 16;
    localparam int FIR_TAPS   = 101;
    localparam int FIR_ACC_W  = 2*FIR_DATA_W + $clog2(FIR_TAPS);
    localparam int COEF_FRAC  = 15;

    // Round half toward +inf, arithmetic shift, clamp to FIR_DATA_W signed.
    function automatic logic signed [FIR_DATA_W-1:0] sat_round(
        input logic signed [FIR_ACC_W-1:0] value,
        input int unsigned                 shift
    );
        longint v;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (FIR_DATA_W-1)) - 1;
        lo = -(longint'(1) <<< (FIR_DATA_W-1));
        v  = longint'(value);
        if (shift > 0)
            v = v + (longint'(1) <<< (shift-1));
        v = v >>> shift;
        if (v > hi)
            v = hi;
        else if (v < lo)
            v = lo;
        return FIR_DATA_W'(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_sync_fifo
// Description : First-word-fall-through synchronous FIFO with level output.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_ready_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_pop;
    logic             w_push;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign w_pop  = rd_ready_i && !empty_o;
    // A simultaneous pop frees the slot the write lands in.
    assign w_push = wr_en_i && (!full_o || w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push)
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (w_pop)
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign level_o   = wr_ptr_q - rd_ptr_q;

endmodule
`default_nettype wire

// File: rtl/fir_requant_decim.sv
`default_nettype none
// ============================================================================
// Module      : fir_requant_decim
// Description : Requantizes the FIR accumulator to OUT_W, decimates and
//               buffers the result on a valid/ready stream.
//               Optional macro FIR_REQUANT_SATCNT_EN adds a saturation counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_requant_decim
    import fir_pkg::*;
#(
    parameter int IN_W       = FIR_ACC_W,
    parameter int OUT_W      = FIR_DATA_W,
    parameter int SHIFT      = COEF_FRAC,
    parameter int DECIM      = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [IN_W-1:0]               in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          ovf_clr,
    output logic                          overflow
`ifdef FIR_REQUANT_SATCNT_EN
   ,output logic [15:0]                   sat_count
`endif
);

    localparam int EXT_W  = IN_W + 1;
    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic signed [EXT_W-1:0] C_MAX =
        {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] C_MIN =
        {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [DCNT_W-1:0] C_DEC_LAST = DCNT_W'(DECIM - 1);

    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_round;
    logic signed [EXT_W-1:0] w_sum;
    logic signed [EXT_W-1:0] w_shifted;
    logic                    w_pos_sat;
    logic                    w_neg_sat;
    logic [OUT_W-1:0]        w_sample;
    logic                    w_keep;

    logic [DCNT_W-1:0]       dcnt_q;
    logic [DCNT_W-1:0]       dcnt_d;
    logic                    s1_valid_q;
    logic [OUT_W-1:0]        s1_data_q;
    logic                    ovf_q;
    logic                    ovf_d;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_drop;

    // Extra sign bit keeps the rounding add from wrapping at the top of range.
    assign w_ext = {in_data[IN_W-1], in_data};

    generate
        if (SHIFT > 0) begin : g_round_en
            assign w_round = EXT_W'(1) <<< (SHIFT - 1);
        end else begin : g_round_dis
            assign w_round = '0;
        end
    endgenerate

    assign w_sum     = w_ext + w_round;
    assign w_shifted = w_sum >>> SHIFT;
    assign w_pos_sat = (w_shifted > C_MAX);
    assign w_neg_sat = (w_shifted < C_MIN);

    always_comb begin
        w_sample = w_shifted[OUT_W-1:0];
        if (w_pos_sat)
            w_sample = C_MAX[OUT_W-1:0];
        else if (w_neg_sat)
            w_sample = C_MIN[OUT_W-1:0];
    end

    assign w_keep = (dcnt_q == '0);

    always_comb begin
        dcnt_d = dcnt_q;
        if (in_valid)
            dcnt_d = (dcnt_q == C_DEC_LAST) ? '0 : dcnt_q + DCNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            dcnt_q     <= dcnt_d;
            s1_valid_q <= in_valid && w_keep;
            if (in_valid)
                s1_data_q <= w_sample;
        end
    end

    fir_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (s1_valid_q),
        .wr_data_i  (s1_data_q),
        .rd_ready_i (out_ready),
        .rd_data_o  (out_data),
        .level_o    (fifo_level),
        .full_o     (w_full),
        .empty_o    (w_empty)
    );

    assign out_valid = !w_empty;
    assign w_drop    = s1_valid_q && w_full && !(out_valid && out_ready);

    // A drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (w_drop)
            ovf_d = 1'b1;
        else if (ovf_clr)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else
            ovf_q <= ovf_d;
    end

    assign overflow = ovf_q;

`ifdef FIR_REQUANT_SATCNT_EN
    logic [15:0] satcnt_q;
    logic [15:0] satcnt_d;

    always_comb begin
        satcnt_d = satcnt_q;
        if (ovf_clr)
            satcnt_d = '0;
        else if (in_valid && (w_pos_sat || w_neg_sat) && (satcnt_q != 16'hFFFF))
            satcnt_d = satcnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            satcnt_q <= '0;
        else
            satcnt_q <= satcnt_d;
    end

    assign sat_count = satcnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_requant_decim.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_requant_decim
// Description : Scoreboard bench; DECIM=1 and DECIM=4 instances share inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_requant_decim;
    import fir_pkg::*;

    localparam int IN_W  = FIR_ACC_W;
    localparam int OUT_W = FIR_DATA_W;
    localparam int SHIFT = COEF_FRAC;
    localparam int DEPTH = 8;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam longint SENTINEL = 64'sd1 <<< 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              in_valid;
    logic [IN_W-1:0]   in_data;
    logic              ovf_clr;
    logic              out_ready;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;
    logic              b_out_ready;
    logic              b_out_valid;
    logic [OUT_W-1:0]  b_out_data;
    logic [LVL_W-1:0]  b_fifo_level;
    logic              b_overflow;
`ifdef FIR_REQUANT_SATCNT_EN
    logic [15:0]       sat_count;
    logic [15:0]       b_sat_count;
`endif

    fir_requant_decim #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_level(fifo_level), .ovf_clr(ovf_clr), .overflow(overflow)
`ifdef FIR_REQUANT_SATCNT_EN
       ,.sat_count(sat_count)
`endif
    );

    fir_requant_decim #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(4), .FIFO_DEPTH(DEPTH)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .fifo_level(b_fifo_level), .ovf_clr(ovf_clr), .overflow(b_overflow)
`ifdef FIR_REQUANT_SATCNT_EN
       ,.sat_count(b_sat_count)
`endif
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    longint exp_q[$];
    longint exp4_q[$];
    int     dcnt = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one sample for one cycle; keep=0 marks a sample the DECIM=1 FIFO drops.
    task automatic drive(input longint v, input longint expv, input bit keep);
        in_valid = 1'b1;
        in_data  = v[IN_W-1:0];
        if (keep)
            exp_q.push_back(expv);
        if (dcnt == 0)
            exp4_q.push_back(expv);
        dcnt = (dcnt == 3) ? 0 : dcnt + 1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || exp4_q.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain_pending", longint'(exp_q.size() + exp4_q.size()), 0);
    endtask

    // Handshakes are evaluated mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        longint e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : SENTINEL;
                check_eq("d1_data", longint'($signed(out_data)), e);
            end else if (!out_valid) begin
                check_eq("d1_idle_zero", longint'(out_data), 0);
            end
            if (b_out_valid && b_out_ready) begin
                e = (exp4_q.size() != 0) ? exp4_q.pop_front() : SENTINEL;
                check_eq("d4_data", longint'($signed(b_out_data)), e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [63:0]            r;
    logic signed [IN_W-1:0] x;

    initial begin
        in_valid    = 1'b0;
        in_data     = '0;
        ovf_clr     = 1'b0;
        out_ready   = 1'b1;
        b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", longint'(out_valid), 0);
        check_eq("rst_out_data", longint'(out_data), 0);
        check_eq("rst_level", longint'(fifo_level), 0);
        check_eq("rst_overflow", longint'(overflow), 0);
        check_eq("rst_d4_valid", longint'(b_out_valid), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Rounding and two-cycle latency
        drive(16384, 1, 1);
        in_valid = 1'b0;
        check_eq("lat_edge1", longint'(out_valid), 0);
        @(posedge clk); #1;
        check_eq("lat_edge2", longint'(out_valid), 1);
        drive(-16384, 0, 1);
        drive(-16385, -1, 1);
        drive(32767, 1, 1);
        drive(98304, 3, 1);
        wait_drain();

        // Saturation
        drive(longint'(1) <<< 31, 32767, 1);
        drive(-(longint'(1) <<< 31), -32768, 1);
        drive((longint'(1) <<< 38) - 1, 32767, 1);
        wait_drain();
`ifdef FIR_REQUANT_SATCNT_EN
        check_eq("sat_count", longint'(sat_count), 3);
`endif

        // Ramp, contiguous then gapped
        for (int k = 0; k < 16; k++)
            drive(longint'(k) * 32768, k, 1);
        wait_drain();
        for (int k = 0; k < 16; k++) begin
            drive(longint'(k) * 32768, k, 1);
            if ($urandom_range(0, 1) == 1)
                idle($urandom_range(1, 3));
        end
        wait_drain();

        // Random values against the package model
        for (int k = 0; k < 20; k++) begin
            r = {$urandom(), $urandom()};
            x = r[IN_W-1:0];
            if (k[0])
                x = x >>> 14;
            drive(longint'(x), longint'(sat_round(x, SHIFT)), 1);
            if ($urandom_range(0, 2) == 0)
                idle(1);
        end
        wait_drain();

        // Backpressure and overflow
        out_ready = 1'b0;
        for (int k = 1; k <= 10; k++)
            drive(longint'(k) * 32768, k, k <= 8);
        idle(3);
        check_eq("bp_level_full", longint'(fifo_level), 8);
        check_eq("bp_overflow_set", longint'(overflow), 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check_eq("bp_ovf_clr", longint'(overflow), 0);
        drive(longint'(11) * 32768, 11, 0);
        in_valid = 1'b0;
        ovf_clr  = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check_eq("bp_set_wins", longint'(overflow), 1);
        check_eq("bp_level_held", longint'(fifo_level), 8);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check_eq("bp_ovf_clr2", longint'(overflow), 0);
        out_ready = 1'b1;
        wait_drain();
        check_eq("bp_level_empty", longint'(fifo_level), 0);

        // Full with simultaneous pop
        out_ready = 1'b0;
        for (int k = 20; k < 28; k++)
            drive(longint'(k) * 32768, k, 1);
        idle(3);
        check_eq("fp_level_full", longint'(fifo_level), 8);
        drive(longint'(28) * 32768, 28, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("fp_level_held", longint'(fifo_level), 8);
        check_eq("fp_no_overflow", longint'(overflow), 0);
        out_ready = 1'b1;
        wait_drain();

        // Asynchronous reset with data buffered
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++)
            drive(longint'(k + 40) * 32768, k + 40, 0);
        idle(3);
        check_eq("mr_level_pre", longint'(fifo_level), 5);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp4_q.delete();
        dcnt = 0;
        #1;
        check_eq("mr_out_valid", longint'(out_valid), 0);
        check_eq("mr_level", longint'(fifo_level), 0);
        check_eq("mr_out_data", longint'(out_data), 0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        drive(longint'(7) * 32768, 7, 1);
        wait_drain();
        check_eq("mr_final_level", longint'(fifo_level), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
